// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_arbiter
// Purpose  : Frame-level arbiter sharing one UART byte transmitter between two
//            byte-stream requesters (0: sensor report formatter, 1: aux/status
//            source). Ownership is locked for a whole frame, ties are broken
//            round-robin, and a stalled frame is abandoned after TIMEOUT idle
//            cycles.
// Options  : `define ARB_CRLF_EN -> append 0x0D, 0x0A after each frame's last
//            byte (no ack given for the terminators).
// Ports    : clk, rst_n           - clock, asynchronous active-low reset
//            reqN_vld/byte/last   - requester N byte handshake (held to ack)
//            reqN_ack             - one-cycle pulse, byte N accepted
//            busy                 - UART transmitter busy
//            tx_byte/tx_byte_vld  - byte and one-cycle strobe to the UART
//            grant                - one-hot current owner, 00 when idle
//            frame_done           - one-cycle pulse, frame completed
//            timeout_err          - one-cycle pulse, frame abandoned
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_arbiter #(
  parameter int TIMEOUT = 1000,
  parameter int TO_W    = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req0_vld,
  input  logic [7:0] req0_byte,
  input  logic       req0_last,
  output logic       req0_ack,
  input  logic       req1_vld,
  input  logic [7:0] req1_byte,
  input  logic       req1_last,
  output logic       req1_ack,
  input  logic       busy,
  output logic [7:0] tx_byte,
  output logic       tx_byte_vld,
  output logic [1:0] grant,
  output logic       frame_done,
  output logic       timeout_err
);

  localparam logic [TO_W-1:0] C_TIMEOUT = TO_W'(TIMEOUT);
  localparam bit              C_TO_EN   = (TIMEOUT != 0);

`ifdef ARB_CRLF_EN
  localparam logic [7:0] C_CR = 8'h0D;
  localparam logic [7:0] C_LF = 8'h0A;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_XFER  = 3'd1,
    S_ISSUE = 3'd2,
    S_GAP   = 3'd3,
    S_CR    = 3'd4,
    S_LF    = 3'd5,
    S_DONE  = 3'd6
  } state_t;

  // Which byte the current ISSUE/GAP pair belongs to, so GAP knows where to go.
  typedef enum logic [1:0] {
    T_DATA = 2'd0,
    T_CR   = 2'd1,
    T_LF   = 2'd2
  } term_t;

  term_t r_term, w_term_nxt;
`else
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_XFER  = 3'd1,
    S_ISSUE = 3'd2,
    S_GAP   = 3'd3,
    S_DONE  = 3'd4
  } state_t;
`endif

  state_t          r_state, w_state_nxt;
  logic [1:0]      r_grant, w_grant_nxt;
  logic            r_last_grant, w_last_grant_nxt;   // index of previous owner
  logic [TO_W-1:0] r_cnt, w_cnt_nxt;
  logic [TO_W-1:0] w_cnt_inc;
  logic [7:0]      r_tx_byte, w_tx_byte_nxt;
  logic            r_last, w_last_nxt;
  logic            r_tx_vld, w_tx_vld_nxt;
  logic            r_ack0, w_ack0_nxt;
  logic            r_ack1, w_ack1_nxt;
  logic            r_done, w_done_nxt;
  logic            r_to, w_to_nxt;

  logic            w_own_vld;
  logic [7:0]      w_own_byte;
  logic            w_own_last;

  assign w_cnt_inc = r_cnt + TO_W'(1);

  // Owner's request lines; only meaningful while a grant is held.
  always_comb begin
    w_own_vld  = r_grant[1] ? req1_vld  : req0_vld;
    w_own_byte = r_grant[1] ? req1_byte : req0_byte;
    w_own_last = r_grant[1] ? req1_last : req0_last;
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_grant_nxt      = r_grant;
    w_last_grant_nxt = r_last_grant;
    w_cnt_nxt        = r_cnt;
    w_tx_byte_nxt    = r_tx_byte;
    w_last_nxt       = r_last;
    w_tx_vld_nxt     = 1'b0;
    w_ack0_nxt       = 1'b0;
    w_ack1_nxt       = 1'b0;
    w_done_nxt       = 1'b0;
    w_to_nxt         = 1'b0;
`ifdef ARB_CRLF_EN
    w_term_nxt       = r_term;
`endif

    case (r_state)
      S_IDLE: begin
        w_cnt_nxt = '0;
`ifdef ARB_CRLF_EN
        w_term_nxt = T_DATA;
`endif
        // On a tie the requester that did not own the previous frame wins.
        if (req0_vld && (!req1_vld || r_last_grant)) begin
          w_grant_nxt = 2'b01;
          w_state_nxt = S_XFER;
        end else if (req1_vld) begin
          w_grant_nxt = 2'b10;
          w_state_nxt = S_XFER;
        end
      end

      S_XFER: begin
        if (w_own_vld) begin
          w_cnt_nxt = '0;
          if (!busy) begin
            w_tx_byte_nxt = w_own_byte;
            w_last_nxt    = w_own_last;
            w_tx_vld_nxt  = 1'b1;
            w_ack0_nxt    = r_grant[0];
            w_ack1_nxt    = r_grant[1];
            w_state_nxt   = S_ISSUE;
          end
        end else if (C_TO_EN && (w_cnt_inc == C_TIMEOUT)) begin
          w_to_nxt         = 1'b1;
          w_grant_nxt      = '0;
          w_last_grant_nxt = r_grant[1];
          w_cnt_nxt        = '0;
          w_state_nxt      = S_IDLE;
        end else if (C_TO_EN) begin
          w_cnt_nxt = w_cnt_inc;
        end
      end

      // Strobe and ack are already registered on entry; this cycle just
      // presents them.
      S_ISSUE: begin
        w_state_nxt = S_GAP;
      end

      // busy is not looked at here: the UART needs a cycle to raise it.
      S_GAP: begin
`ifdef ARB_CRLF_EN
        if (r_term == T_LF) begin
          w_done_nxt  = 1'b1;
          w_state_nxt = S_DONE;
        end else if (r_term == T_CR) begin
          w_state_nxt = S_LF;
        end else if (r_last) begin
          w_state_nxt = S_CR;
        end else begin
          w_state_nxt = S_XFER;
        end
`else
        if (r_last) begin
          w_done_nxt  = 1'b1;
          w_state_nxt = S_DONE;
        end else begin
          w_state_nxt = S_XFER;
        end
`endif
      end

`ifdef ARB_CRLF_EN
      S_CR: begin
        if (!busy) begin
          w_tx_byte_nxt = C_CR;
          w_tx_vld_nxt  = 1'b1;
          w_term_nxt    = T_CR;
          w_state_nxt   = S_ISSUE;
        end
      end

      S_LF: begin
        if (!busy) begin
          w_tx_byte_nxt = C_LF;
          w_tx_vld_nxt  = 1'b1;
          w_term_nxt    = T_LF;
          w_state_nxt   = S_ISSUE;
        end
      end
`endif

      S_DONE: begin
        w_grant_nxt      = '0;
        w_last_grant_nxt = r_grant[1];
        w_state_nxt      = S_IDLE;
      end

      default: begin
        w_grant_nxt = '0;
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_grant      <= '0;
      r_last_grant <= 1'b1;
      r_cnt        <= '0;
      r_tx_byte    <= '0;
      r_last       <= 1'b0;
      r_tx_vld     <= 1'b0;
      r_ack0       <= 1'b0;
      r_ack1       <= 1'b0;
      r_done       <= 1'b0;
      r_to         <= 1'b0;
`ifdef ARB_CRLF_EN
      r_term       <= T_DATA;
`endif
    end else begin
      r_state      <= w_state_nxt;
      r_grant      <= w_grant_nxt;
      r_last_grant <= w_last_grant_nxt;
      r_cnt        <= w_cnt_nxt;
      r_tx_byte    <= w_tx_byte_nxt;
      r_last       <= w_last_nxt;
      r_tx_vld     <= w_tx_vld_nxt;
      r_ack0       <= w_ack0_nxt;
      r_ack1       <= w_ack1_nxt;
      r_done       <= w_done_nxt;
      r_to         <= w_to_nxt;
`ifdef ARB_CRLF_EN
      r_term       <= w_term_nxt;
`endif
    end
  end

  assign req0_ack    = r_ack0;
  assign req1_ack    = r_ack1;
  assign tx_byte     = r_tx_byte;
  assign tx_byte_vld = r_tx_vld;
  assign grant       = r_grant;
  assign frame_done  = r_done;
  assign timeout_err = r_to;

endmodule
`default_nettype wire

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Frame-level arbiter that shares one UART byte transmitter between two byte-stream requesters.
- Requester 0 is the sensor report formatter (temperature/humidity ASCII frame). Requester 1 is the auxiliary/status message source.
- Grant is locked for a whole frame, ending at the byte flagged last. Ties are broken round-robin.
- A stalled frame is abandoned after a programmable idle timeout.

Parameters:
- TIMEOUT, 1000, consecutive XFER cycles with granted requester's vld low before the frame is abandoned; 0 disables the timeout.
- TO_W, 16, width of the timeout counter; must satisfy TIMEOUT < 2^TO_W.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous reset, active-low
- req0_vld  in  1  requester 0 has a byte on req0_byte; held until req0_ack
- req0_byte  in  8  requester 0 data byte
- req0_last  in  1  req0_byte is the final byte of its frame
- req0_ack  out  1  one-cycle pulse: req0 byte accepted, requester may advance
- req1_vld / req1_byte / req1_last / req1_ack  same as requester 0, for requester 1
- busy  in  1  UART transmitter busy
- tx_byte  out  8  byte to UART
- tx_byte_vld  out  1  one-cycle pulse: tx_byte valid, UART must accept it
- grant  out  2  one-hot current owner; 00 when no owner
- frame_done  out  1  one-cycle pulse when a frame completes normally
- timeout_err  out  1  one-cycle pulse when a frame is abandoned

Behaviour:
- Reset state: all outputs 0; state IDLE; last_grant = 1 (so requester 0 wins the first tie); timeout counter 0. Reset mid-frame aborts immediately; no partial byte pulse is produced.
- All outputs are registered. Byte, last flag and owner are captured in registers; requester inputs are never passed combinationally to the outputs.
- States: IDLE, XFER, ISSUE, GAP, CR, LF (CR and LF only with ARB_CRLF_EN), DONE.
- IDLE:
  - Only one vld high: grant that requester.
  - Both vld high: grant the requester != last_grant.
  - On grant, set grant one-hot and go to XFER.
  - busy is ignored in IDLE.
- XFER:
  - When the owner's vld=1 and busy=0: capture the owner's byte and last flag, go to ISSUE.
  - While owner vld=0: increment the timeout counter; vld=1 clears it.
  - Counter reaching TIMEOUT (TIMEOUT≠0): timeout_err=1 for one cycle, grant cleared, last_grant = owner, go to IDLE.
  - The other requester's vld is ignored while a grant is held.
- ISSUE (1 cycle):
  - tx_byte_vld=1, tx_byte = captured byte, owner's ack=1.
  - Go to GAP.
- GAP (1 cycle): busy is not sampled, to cover the UART's busy-assert latency.
  - Captured last=0: go to XFER.
  - Captured last=1: go to DONE, or to CR with ARB_CRLF_EN.
- DONE (1 cycle):
  - frame_done=1, last_grant = owner, grant cleared.
  - Go to IDLE. Re-arbitration happens next cycle, so there is at least one idle cycle between frames.
- Latency: with busy=0, req vld rise to tx_byte_vld = 2 cycles (IDLE→XFER→ISSUE). Steady-state minimum byte spacing = 3 cycles (XFER, ISSUE, GAP).
- tx_byte holds its last value between pulses. ackN is never high unless grant[N]=1 in that cycle.
- Single-byte frames (vld and last on the first byte) are legal.
- vld dropping mid-frame without timeout: no output; resume on the next vld.

Optional Feature:
- Macro ARB_CRLF_EN.
- Defined:
  - After the last byte's GAP, the arbiter issues 0x0D (state CR), then 0x0A (state LF).
  - Each terminator byte waits for busy=0, issues a one-cycle tx_byte_vld, then takes one GAP cycle.
  - No ack is given for CR or LF. Grant is held until DONE.
- Undefined: CR and LF states are absent; GAP goes directly to DONE.

Test Plan:
- Req0 frame 0x32,0x35,0x2E(last), busy=0 → three tx_byte_vld pulses at cycles 2, 5, 8 after vld; matching req0_ack each; frame_done 2 cycles after the last pulse; grant=01 then 00.
- req0_vld and req1_vld rise the same cycle after reset → req0 served first (grant=01), then req1 (grant=10); repeating both → alternation 0,1,0,1.
- busy held high 50 cycles during req1 frame → no tx_byte_vld and no ack while busy=1; first pulse 1 cycle after busy falls (captured at busy=0, issued next).
- TIMEOUT=8, req0 sends 1 non-last byte then drops vld → timeout_err 8 cycles after entering XFER with vld low; grant 00; a pending req1 is granted next.
- ARB_CRLF_EN, req1 single byte 0x41 last → tx bytes 0x41, 0x0D, 0x0A; one req1_ack only; frame_done after 0x0A.
- rst_n low between two bytes of a frame → all outputs 0 asynchronously; after release, req0 wins a tie again.
